// File: rtl/cxu_responder.sv
// cxu_responder: fabric-side CXU responder. Executes ALU and per-context
// accumulator functions and returns ID-tagged results through an in-order FIFO.
// Optional iterative shift-add multiplier (func 6): define CXU_RESPONDER_MUL_EN.
module cxu_responder #(
  parameter int unsigned ID_W       = 4,
  parameter int unsigned CXU_ID_W   = 2,
  parameter int unsigned CXU_ID     = 0,
  parameter int unsigned STATE_ID_W = 2,
  parameter int unsigned FUNC_ID_W  = 3,
  parameter int unsigned INSN_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STATUS_W   = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ID_W-1:0]       req_id,
  input  logic [CXU_ID_W-1:0]   req_cxu,
  input  logic [STATE_ID_W-1:0] req_state,
  input  logic [FUNC_ID_W-1:0]  req_func,
  input  logic [INSN_W-1:0]     req_insn,
  input  logic [DATA_W-1:0]     req_data0,
  input  logic [DATA_W-1:0]     req_data1,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [STATUS_W-1:0]   resp_status,
  output logic [DATA_W-1:0]     resp_data
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned NUM_ACC = 1 << STATE_ID_W;

  localparam logic [FUNC_ID_W-1:0] F_ADD    = FUNC_ID_W'(0);
  localparam logic [FUNC_ID_W-1:0] F_SUB    = FUNC_ID_W'(1);
  localparam logic [FUNC_ID_W-1:0] F_XOR    = FUNC_ID_W'(2);
  localparam logic [FUNC_ID_W-1:0] F_ACC    = FUNC_ID_W'(3);
  localparam logic [FUNC_ID_W-1:0] F_RDACC  = FUNC_ID_W'(4);
  localparam logic [FUNC_ID_W-1:0] F_CLRACC = FUNC_ID_W'(5);

  typedef struct packed {
    logic [ID_W-1:0]     id;
    logic [STATUS_W-1:0] status;
    logic [DATA_W-1:0]   data;
  } resp_t;

  resp_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DATA_W-1:0] acc [NUM_ACC];

  logic        idle;
  logic        accept;
  logic        acc_push;
  logic        mul_done;
  logic        push;
  logic        pop;
  logic        op_err;
  logic [DATA_W-1:0] op_data;
  logic [DATA_W-1:0] acc_cur;
  logic [DATA_W-1:0] acc_sum;
  resp_t       push_entry;
  resp_t       mul_entry;
  logic        unused_insn;

`ifdef CXU_RESPONDER_MUL_EN
  localparam int unsigned ITER_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [FUNC_ID_W-1:0] F_MUL = FUNC_ID_W'(6);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic              op_mul;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_acc;
  logic [DATA_W-1:0] mul_sum;
  logic [ID_W-1:0]   mul_id;
  logic [ITER_W-1:0] iter;
`endif

  // The raw instruction word carries nothing this unit needs.
  assign unused_insn = ^req_insn;

  assign req_ready   = idle && (count < CNT_W'(FIFO_DEPTH)) && !rst;
  assign accept      = req_valid && req_ready;
  assign resp_valid  = (count != '0) && !rst;
  assign pop         = resp_valid && resp_ready;
  assign push        = acc_push || mul_done;
  assign resp_id     = mem[rd_ptr].id;
  assign resp_status = mem[rd_ptr].status;
  assign resp_data   = mem[rd_ptr].data;

  // Decode the request into a single-cycle result or an error.
  always_comb begin
    op_err  = 1'b0;
    op_data = '0;
    acc_cur = acc[req_state];
    acc_sum = acc_cur + req_data0 + req_data1;
`ifdef CXU_RESPONDER_MUL_EN
    op_mul  = 1'b0;
`endif
    case (req_func)
      F_ADD:    op_data = req_data0 + req_data1;
      F_SUB:    op_data = req_data0 - req_data1;
      F_XOR:    op_data = req_data0 ^ req_data1;
      F_ACC:    op_data = acc_sum;
      F_RDACC:  op_data = acc_cur;
      F_CLRACC: op_data = acc_cur;
`ifdef CXU_RESPONDER_MUL_EN
      F_MUL:    op_mul  = 1'b1;
`endif
      default:  op_err  = 1'b1;
    endcase
    if (req_cxu != CXU_ID_W'(CXU_ID)) op_err = 1'b1;
    if (op_err) begin
      op_data = '0;
`ifdef CXU_RESPONDER_MUL_EN
      op_mul  = 1'b0;
`endif
    end
  end

  // Accumulator contexts: updated only by accepted, error-free ACC/CLRACC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) acc[STATE_ID_W'(i)] <= '0;
    end else if (accept && !op_err) begin
      if (req_func == F_ACC) acc[req_state] <= acc_sum;
      else if (req_func == F_CLRACC) acc[req_state] <= '0;
    end
  end

`ifdef CXU_RESPONDER_MUL_EN
  assign idle      = (state == IDLE);
  assign acc_push  = accept && !op_mul;
  assign mul_sum   = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_done  = (state == BUSY) && (iter == '0);
  assign mul_entry = '{id: mul_id, status: STATUS_W'(0), data: mul_sum};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: IDLE -> BUSY on MUL accept, back on the last iteration.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && op_mul) state_next = BUSY;
      BUSY:    if (iter == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift-add multiplier datapath, one multiplier bit per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a   <= '0;
      mul_b   <= '0;
      mul_acc <= '0;
      mul_id  <= '0;
      iter    <= '0;
    end else if (accept && op_mul) begin
      mul_a   <= req_data0;
      mul_b   <= req_data1;
      mul_acc <= '0;
      mul_id  <= req_id;
      iter    <= ITER_W'(DATA_W - 1);
    end else if (state == BUSY) begin
      mul_acc <= mul_sum;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
      iter    <= iter - ITER_W'(1);
    end
  end
`else
  assign idle      = 1'b1;
  assign acc_push  = accept;
  assign mul_done  = 1'b0;
  assign mul_entry = '0;
`endif

  // Select what enters the FIFO: a finished multiply or the accepted request.
  always_comb begin
    push_entry = mul_entry;
    if (!mul_done) push_entry = '{id: req_id, status: STATUS_W'(op_err), data: op_data};
  end

  // In-order response FIFO; storage cleared on reset so head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[PTR_W'(i)] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_cxu_responder.sv
// tb_cxu_responder: randomized self-checking bench for cxu_responder against a
// queue-based transaction model. Honours CXU_RESPONDER_MUL_EN like the design.
module tb_cxu_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_id;
  logic [1:0]  req_cxu;
  logic [1:0]  req_state;
  logic [2:0]  req_func;
  logic [31:0] req_insn;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_id;
  logic [0:0]  resp_status;
  logic [31:0] resp_data;

  cxu_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
    .req_cxu(req_cxu), .req_state(req_state), .req_func(req_func),
    .req_insn(req_insn), .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_status(resp_status), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic        st;
    logic [31:0] data;
  } rsp_t;

  // Transaction model: expected FIFO contents, accumulators, pending multiply.
  rsp_t        q[$];
  logic [31:0] m_acc [4];
  bit          m_busy;
  int          m_left;
  rsp_t        m_mul;

  int compared = 0;
  int mismatched = 0;

  logic obs_ready, obs_valid, exp_ready, exp_valid, took;
  rsp_t obs_head, exp_head;

  function automatic rsp_t model_op(input logic [3:0] id, input logic [1:0] cxu,
                                    input logic [1:0] st, input logic [2:0] fn,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output bit is_mul);
    rsp_t r;
    r.id = id; r.st = 1'b0; r.data = '0; is_mul = 1'b0;
    if (cxu != 2'd0) begin
      r.st = 1'b1;
      return r;
    end
    case (fn)
      3'd0: r.data = a + b;
      3'd1: r.data = a - b;
      3'd2: r.data = a ^ b;
      3'd3: begin m_acc[st] = m_acc[st] + a + b; r.data = m_acc[st]; end
      3'd4: r.data = m_acc[st];
      3'd5: begin r.data = m_acc[st]; m_acc[st] = '0; end
`ifdef CXU_RESPONDER_MUL_EN
      3'd6: begin r.data = a * b; is_mul = 1'b1; end
`endif
      default: r.st = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [38:0] view(input logic r, input logic v, input rsp_t h);
    return {r, v, (v ? h : rsp_t'(0))};
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_left = 0;
    foreach (m_acc[i]) m_acc[i] = '0;
  endtask

  // One clock: drive at posedge+1, sample at negedge, advance the model.
  task automatic cycle(input logic v, input logic [3:0] id, input logic [1:0] cxu,
                       input logic [1:0] st, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic rr);
    rsp_t r;
    bit   is_mul;
    req_valid = v; req_id = id; req_cxu = cxu; req_state = st; req_func = fn;
    req_data0 = a; req_data1 = b; req_insn = $urandom; resp_ready = rr;
    @(negedge clk);
    obs_ready = req_ready;
    obs_valid = resp_valid;
    obs_head  = {resp_id, resp_status, resp_data};
    exp_ready = !m_busy && (q.size() < DEPTH);
    exp_valid = (q.size() != 0);
    exp_head  = exp_valid ? q[0] : rsp_t'(0);
    took      = v && exp_ready;
    if (exp_valid && rr) void'(q.pop_front());
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        q.push_back(m_mul);
        m_busy = 1'b0;
      end
    end else if (took) begin
      r = model_op(id, cxu, st, fn, a, b, is_mul);
      if (is_mul) begin
        m_busy = 1'b1;
        m_left = DW;
        m_mul  = r;
      end else begin
        q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() != 0 || m_busy); i++) cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_id = '0; req_cxu = '0;
    req_state = '0; req_func = '0; req_insn = '0; req_data0 = '0; req_data1 = '0;
    @(posedge clk); #1;
    @(negedge clk);
    if ({req_ready, resp_valid, resp_id, resp_status, resp_data} !== 39'd0) begin
      mismatched++;
      $display("FAIL reset_cycle: got %h want %h", {req_ready, resp_valid, resp_id, resp_status, resp_data}, 39'd0);
    end
    compared++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    if ({req_ready, resp_valid, resp_id, resp_status, resp_data} !== {2'b10, 37'd0}) begin
      mismatched++;
      $display("FAIL post_reset: got %h want %h", {req_ready, resp_valid, resp_id, resp_status, resp_data}, {2'b10, 37'd0});
    end
    compared++;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    cycle(1'b1, 4'd3, 2'd0, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    if (view(obs_ready, obs_valid, obs_head) !== {2'b11, 4'd3, 1'b0, 32'h0000_0001}) begin
      mismatched++;
      $display("FAIL add_wrap: got %h want %h", view(obs_ready, obs_valid, obs_head), {2'b11, 4'd3, 1'b0, 32'h0000_0001});
    end
    compared++;
    for (int c = 0; c < 120; c++) begin
      cycle($urandom_range(0, 1) != 0, 4'($urandom), 2'd0, 2'($urandom), 3'($urandom_range(0, 2)),
            $urandom, $urandom, $urandom_range(0, 3) != 0);
      if (view(obs_ready, obs_valid, obs_head) !== view(exp_ready, exp_valid, exp_head)) begin
        mismatched++;
        $display("FAIL alu_rand c=%0d: got %h want %h", c, view(obs_ready, obs_valid, obs_head), view(exp_ready, exp_valid, exp_head));
      end
      compared++;
    end
    drain();
  endtask

  task automatic test_acc();
    logic [2:0]  fn_t [6];
    logic [1:0]  st_t [6];
    logic [31:0] a_t [6];
    logic [31:0] b_t [6];
    logic [31:0] d_t [6];
    fn_t = '{3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd4};
    st_t = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};
    a_t  = '{32'd5, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    b_t  = '{32'd6, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    d_t  = '{32'd11, 32'd13, 32'd13, 32'd0, 32'd13, 32'd0};
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) cycle(1'b1, 4'(k), 2'd0, st_t[k], fn_t[k], a_t[k], b_t[k], 1'b1);
      else       cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
      if (k > 0 && view(obs_ready, obs_valid, obs_head) !== {2'b11, 4'(k - 1), 1'b0, d_t[k - 1]}) begin
        mismatched++;
        $display("FAIL acc_seq k=%0d: got %h want %h", k, view(obs_ready, obs_valid, obs_head), {2'b11, 4'(k - 1), 1'b0, d_t[k - 1]});
      end
      if (k > 0) compared++;
    end
  endtask

  task automatic test_error();
    logic [1:0]  cx_t [6];
    logic [2:0]  fn_t [6];
    logic [31:0] a_t [6];
    logic [31:0] b_t [6];
    logic        s_t [6];
    logic [31:0] d_t [6];
    cx_t = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
    fn_t = '{3'd3, 3'd3, 3'd7, 3'd5, 3'd0, 3'd4};
    a_t  = '{32'd3, 32'd100, 32'd9, 32'd0, 32'd5, 32'd0};
    b_t  = '{32'd4, 32'd0, 32'd9, 32'd0, 32'd5, 32'd0};
    s_t  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    d_t  = '{32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7};
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) cycle(1'b1, 4'(k + 8), cx_t[k], 2'd2, fn_t[k], a_t[k], b_t[k], 1'b1);
      else       cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
      if (k > 0 && view(obs_ready, obs_valid, obs_head) !== {2'b11, 4'(k + 7), s_t[k - 1], d_t[k - 1]}) begin
        mismatched++;
        $display("FAIL err_seq k=%0d: got %h want %h", k, view(obs_ready, obs_valid, obs_head), {2'b11, 4'(k + 7), s_t[k - 1], d_t[k - 1]});
      end
      if (k > 0) compared++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a_t [5];
    logic [31:0] b_t [5];
    logic        rdy_t [8];
    int r = 0;
    int nxt = 3;
    rdy_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    foreach (a_t[i]) begin a_t[i] = $urandom; b_t[i] = $urandom; end
    for (int c = 0; c < 8; c++) begin
      cycle(r < 5, 4'(r + 1), 2'd0, 2'd0, 3'd0, a_t[r < 5 ? r : 0], b_t[r < 5 ? r : 0], c >= 6);
      if (view(obs_ready, obs_valid, obs_head) !== view(exp_ready, exp_valid, exp_head)) begin
        mismatched++;
        $display("FAIL bp_model c=%0d: got %h want %h", c, view(obs_ready, obs_valid, obs_head), view(exp_ready, exp_valid, exp_head));
      end
      compared++;
      if (obs_ready !== rdy_t[c]) begin
        mismatched++;
        $display("FAIL bp_ready c=%0d: got %b want %b", c, obs_ready, rdy_t[c]);
      end
      compared++;
      if (c >= 4 && c <= 6) begin
        if ({obs_valid, obs_head.id} !== {1'b1, 4'd1}) begin
          mismatched++;
          $display("FAIL bp_head c=%0d: got %h want %h", c, {obs_valid, obs_head.id}, {1'b1, 4'd1});
        end
        compared++;
      end
      if (took) r++;
    end
    if (r != 5) begin
      mismatched++;
      $display("FAIL bp_accepted: got %0d want 5", r);
    end
    compared++;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
      if (view(obs_ready, obs_valid, obs_head) !== view(exp_ready, exp_valid, exp_head)) begin
        mismatched++;
        $display("FAIL bp_drain c=%0d: got %h want %h", c, view(obs_ready, obs_valid, obs_head), view(exp_ready, exp_valid, exp_head));
      end
      compared++;
      if (obs_valid) begin
        if (obs_head.id !== 4'(nxt)) begin
          mismatched++;
          $display("FAIL bp_order: got %0d want %0d", obs_head.id, nxt);
        end
        compared++;
        nxt++;
      end
    end
    if (nxt != 6) begin
      mismatched++;
      $display("FAIL bp_drained: got next id %0d want 6", nxt);
    end
    compared++;
  endtask

  task automatic test_mul();
`ifdef CXU_RESPONDER_MUL_EN
    int   n_low = 0;
    int   first_v = -1;
    int   add_at = -1;
    rsp_t vh = '0;
    cycle(1'b1, 4'd9, 2'd0, 2'd0, 3'd6, 32'h0001_0001, 32'h0001_0001, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      cycle(add_at < 0, 4'd10, 2'd0, 2'd0, 3'd0, 32'd20, 32'd22, 1'b1);
      if (view(obs_ready, obs_valid, obs_head) !== view(exp_ready, exp_valid, exp_head)) begin
        mismatched++;
        $display("FAIL mul_model c=%0d: got %h want %h", c, view(obs_ready, obs_valid, obs_head), view(exp_ready, exp_valid, exp_head));
      end
      compared++;
      if (add_at < 0 && !obs_ready) n_low++;
      if (first_v < 0 && obs_valid) begin first_v = c; vh = obs_head; end
      if (add_at < 0 && obs_ready) add_at = c;
    end
    if (n_low != 32) begin mismatched++; $display("FAIL mul_busy_cycles: got %0d want 32", n_low); end
    compared++;
    if (first_v != 33) begin mismatched++; $display("FAIL mul_latency: got %0d want 33", first_v); end
    compared++;
    if (vh !== {4'd9, 1'b0, 32'h0002_0001}) begin
      mismatched++;
      $display("FAIL mul_result: got %h want %h", vh, {4'd9, 1'b0, 32'h0002_0001});
    end
    compared++;
    if (add_at != 33) begin mismatched++; $display("FAIL mul_next_accept: got %0d want 33", add_at); end
    compared++;
`else
    cycle(1'b1, 4'd9, 2'd0, 2'd0, 3'd6, 32'h0001_0001, 32'h0001_0001, 1'b1);
    cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
    if (view(obs_ready, obs_valid, obs_head) !== {2'b11, 4'd9, 1'b1, 32'd0}) begin
      mismatched++;
      $display("FAIL mul_disabled: got %h want %h", view(obs_ready, obs_valid, obs_head), {2'b11, 4'd9, 1'b1, 32'd0});
    end
    compared++;
`endif
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 3) != 0, 4'($urandom),
            ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
            2'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
            $urandom_range(0, 4) != 0);
      if (view(obs_ready, obs_valid, obs_head) !== view(exp_ready, exp_valid, exp_head)) begin
        mismatched++;
        $display("FAIL rand c=%0d: got %h want %h", c, view(obs_ready, obs_valid, obs_head), view(exp_ready, exp_valid, exp_head));
      end
      compared++;
    end
    drain();
  endtask

  task automatic test_reset_busy();
    cycle(1'b1, 4'd1, 2'd0, 2'd0, 3'd3, 32'd7, 32'd8, 1'b0);
    cycle(1'b1, 4'd2, 2'd0, 2'd0, 3'd0, 32'd1, 32'd1, 1'b0);
`ifdef CXU_RESPONDER_MUL_EN
    cycle(1'b1, 4'd3, 2'd0, 2'd0, 3'd6, 32'd5, 32'd6, 1'b0);
    for (int c = 0; c < 4; c++) cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    if (obs_ready !== 1'b0) begin mismatched++; $display("FAIL rb_busy: got ready %b want 0", obs_ready); end
    compared++;
`else
    cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
`endif
    if ({obs_valid, obs_head.id} !== {1'b1, 4'd1}) begin
      mismatched++;
      $display("FAIL rb_queued: got %h want %h", {obs_valid, obs_head.id}, {1'b1, 4'd1});
    end
    compared++;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    if (view(obs_ready, obs_valid, obs_head) !== {2'b10, 37'd0}) begin
      mismatched++;
      $display("FAIL rb_flushed: got %h want %h", view(obs_ready, obs_valid, obs_head), {2'b10, 37'd0});
    end
    compared++;
    cycle(1'b1, 4'd5, 2'd0, 2'd0, 3'd4, 32'd0, 32'd0, 1'b1);
    cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
    if (view(obs_ready, obs_valid, obs_head) !== {2'b11, 4'd5, 1'b0, 32'd0}) begin
      mismatched++;
      $display("FAIL rb_rdacc: got %h want %h", view(obs_ready, obs_valid, obs_head), {2'b11, 4'd5, 1'b0, 32'd0});
    end
    compared++;
    for (int c = 0; c < 40; c++) begin
      cycle(1'b0, 4'd0, 2'd0, 2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
      if (view(obs_ready, obs_valid, obs_head) !== view(exp_ready, exp_valid, exp_head)) begin
        mismatched++;
        $display("FAIL rb_quiet c=%0d: got %h want %h", c, view(obs_ready, obs_valid, obs_head), view(exp_ready, exp_valid, exp_head));
      end
      compared++;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_acc();
    test_error();
    test_backpressure();
    test_mul();
    test_random();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1);
  end

endmodule
